// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
//
// Rectangle-fill engine that owns the single plot port of a 160x120 VGA
// adapter. Two requesters share it: requester 0 (background/erase) and
// requester 1 (sprite draw). One rectangle command is accepted at a time,
// scanned in raster order at one pixel per clock, and driven straight into
// the adapter. Simultaneous requests are granted round-robin.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   reqN_valid / reqN_ready     command handshake (valid & ready = accept)
//   reqN_x, reqN_y              top-left corner (x 0..159, y 0..119)
//   reqN_w, reqN_h              rectangle size in pixels (0 = empty)
//   reqN_colour                 fill colour
//   reqN_done                   one-cycle pulse when that rectangle finishes
//   x, y, colour, plot          registered pixel write to the adapter
//   busy                        high while a rectangle is being scanned
// ---------------------------------------------------------------------------
module vga_draw_arbiter #(
   parameter int DIM_W    = 6,
   parameter int COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [7:0]          req0_x,
   input  logic [6:0]          req0_y,
   input  logic [DIM_W-1:0]    req0_w,
   input  logic [DIM_W-1:0]    req0_h,
   input  logic [COLOUR_W-1:0] req0_colour,
   output logic                req0_done,

   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [7:0]          req1_x,
   input  logic [6:0]          req1_y,
   input  logic [DIM_W-1:0]    req1_w,
   input  logic [DIM_W-1:0]    req1_h,
   input  logic [COLOUR_W-1:0] req1_colour,
   output logic                req1_done,

   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy
);

   typedef enum logic {IDLE, DRAW} state_t;

   state_t               state;
   logic                 last_grant;   // id granted most recently
   logic                 cur_id;       // id of the rectangle being drawn
   logic                 zero_q;       // latched command has w==0 or h==0
   logic [7:0]           x0_q;
   logic [6:0]           y0_q;
   logic [DIM_W-1:0]     w_q;
   logic [DIM_W-1:0]     h_q;
   logic [COLOUR_W-1:0]  colour_q;
   // cx/cy index the pixel currently presented on x/y/plot.
   logic [DIM_W-1:0]     cx;
   logic [DIM_W-1:0]     cy;

   // Arbitration and next-pixel datapath
   logic                 grant0, grant1, sel_id;
   logic [7:0]           sel_x;
   logic [6:0]           sel_y;
   logic [DIM_W-1:0]     sel_w, sel_h;
   logic [COLOUR_W-1:0]  sel_colour;
   logic                 row_end, last_pix;
   logic [DIM_W-1:0]     ncx, ncy;
   logic [7:0]           base_x;
   logic [6:0]           base_y;
   logic [DIM_W-1:0]     off_x, off_y;
   logic                 blank;
   logic [8:0]           sum_x;
   logic [7:0]           sum_y;
   logic                 pix_on;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      // A lone requester always wins; on a conflict the one not granted
      // last time wins.
      grant0     = req0_valid && (!req1_valid || last_grant);
      grant1     = req1_valid && (!req0_valid || !last_grant);
      sel_id     = grant1;

      sel_x      = grant1 ? req1_x      : req0_x;
      sel_y      = grant1 ? req1_y      : req0_y;
      sel_w      = grant1 ? req1_w      : req0_w;
      sel_h      = grant1 ? req1_h      : req0_h;
      sel_colour = grant1 ? req1_colour : req0_colour;

      row_end  = (cx == w_q - DIM_W'(1));
      last_pix = zero_q || (row_end && (cy == h_q - DIM_W'(1)));
      ncx      = row_end ? '0 : cx + DIM_W'(1);
      ncy      = row_end ? cy + DIM_W'(1) : cy;

      // Pixel (0,0) is registered on the handshake edge straight from the
      // request, so the first pixel appears the cycle after acceptance.
      base_x = x0_q;
      base_y = y0_q;
      off_x  = ncx;
      off_y  = ncy;
      blank  = 1'b0;
      if (state == IDLE) begin
         base_x = sel_x;
         base_y = sel_y;
         off_x  = '0;
         off_y  = '0;
         blank  = (sel_w == '0) || (sel_h == '0);
      end

      // Wide sums so pixels past the right/bottom edge are clipped rather
      // than wrapping onto the opposite edge.
      sum_x  = 9'(base_x) + 9'(off_x);
      sum_y  = 8'(base_y) + 8'(off_y);
      pix_on = !blank && (sum_x < 9'd160) && (sum_y < 8'd120);
   end

   assign req0_ready = (state == IDLE) && grant0;
   assign req1_ready = (state == IDLE) && grant1;
   assign busy       = (state == DRAW);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         zero_q     <= 1'b0;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         colour_q   <= '0;
         cx         <= '0;
         cy         <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  cur_id     <= sel_id;
                  last_grant <= sel_id;
                  zero_q     <= blank;
                  x0_q       <= sel_x;
                  y0_q       <= sel_y;
                  w_q        <= sel_w;
                  h_q        <= sel_h;
                  colour_q   <= sel_colour;
                  cx         <= '0;
                  cy         <= '0;
                  x          <= sum_x[7:0];
                  y          <= sum_y[6:0];
                  colour     <= sel_colour;
                  plot       <= pix_on;
                  state      <= DRAW;
               end
            end
            DRAW: begin
               if (last_pix) begin
                  plot      <= 1'b0;
                  req0_done <= !cur_id;
                  req1_done <= cur_id;
                  state     <= IDLE;
               end else begin
                  cx     <= ncx;
                  cy     <= ncy;
                  x      <= sum_x[7:0];
                  y      <= sum_y[6:0];
                  colour <= colour_q;
                  plot   <= pix_on;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_draw_arbiter
//
// Scoreboard bench: each accepted command pushes its expected pixels (with
// the cycle each must appear) and its expected done pulse into queues; an
// independent monitor pops and compares whenever plot or a done pulse shows.
// ---------------------------------------------------------------------------
module tb_vga_draw_arbiter;

   localparam int DIM_W    = 6;
   localparam int COLOUR_W = 3;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
      int col;
   } cmd_t;

   typedef struct {
      int x;
      int y;
      int col;
      int cyc;
   } pix_t;

   typedef struct {
      int id;
      int cyc;
   } done_t;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                req0_valid = 1'b0, req1_valid = 1'b0;
   logic                req0_ready, req1_ready;
   logic [7:0]          req0_x = '0, req1_x = '0;
   logic [6:0]          req0_y = '0, req1_y = '0;
   logic [DIM_W-1:0]    req0_w = '0, req1_w = '0;
   logic [DIM_W-1:0]    req0_h = '0, req1_h = '0;
   logic [COLOUR_W-1:0] req0_colour = '0, req1_colour = '0;
   logic                req0_done, req1_done;
   logic [7:0]          x;
   logic [6:0]          y;
   logic [COLOUR_W-1:0] colour;
   logic                plot, busy;

   vga_draw_arbiter #(.DIM_W(DIM_W), .COLOUR_W(COLOUR_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_x(req0_x), .req0_y(req0_y), .req0_w(req0_w), .req0_h(req0_h),
      .req0_colour(req0_colour), .req0_done(req0_done),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_x(req1_x), .req1_y(req1_y), .req1_w(req1_w), .req1_h(req1_h),
      .req1_colour(req1_colour), .req1_done(req1_done),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
   );

   always #5 clk = ~clk;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    busy_cnt = 0;
   pix_t  exp_pix[$];
   done_t exp_done[$];
   int    exp_grant[$];
   int    hs_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      pix_t  p;
      done_t d;
      check("ready_only_idle", int'(busy && (req0_ready || req1_ready)), 0);
      check("ready_onehot", int'(req0_ready && req1_ready), 0);
      if (plot === 1'b1) begin
         if (exp_pix.size() == 0) begin
            check("unexpected_plot", 1, 0);
         end else begin
            p = exp_pix.pop_front();
            check("pix_x", int'(x), p.x);
            check("pix_y", int'(y), p.y);
            check("pix_colour", int'(colour), p.col);
            check("pix_cycle", cyc, p.cyc);
         end
      end
      if (req0_done === 1'b1 || req1_done === 1'b1) begin
         check("done_onehot", int'(req0_done && req1_done), 0);
         if (exp_done.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            d = exp_done.pop_front();
            check("done_id", int'(req1_done), d.id);
            check("done_cycle", cyc, d.cyc);
         end
      end
      if (busy === 1'b1) busy_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   // Expected pixels of a command accepted in cycle t: pixel k in raster
   // order appears at t+1+k, clipped pixels produce no plot.
   task automatic record(input int id, input cmd_t c, input int t);
      pix_t  p;
      done_t d;
      int    n;
      if (exp_grant.size() != 0) check("grant_order", id, exp_grant.pop_front());
      hs_cyc.push_back(t);
      for (int r = 0; r < c.h; r++) begin
         for (int q = 0; q < c.w; q++) begin
            if (c.x + q < 160 && c.y + r < 120) begin
               p.x   = c.x + q;
               p.y   = c.y + r;
               p.col = c.col;
               p.cyc = t + 1 + r * c.w + q;
               exp_pix.push_back(p);
            end
         end
      end
      n = c.w * c.h;
      if (n == 0) n = 1;
      d.id  = id;
      d.cyc = t + n + 1;
      exp_done.push_back(d);
   endtask

   task automatic load0(input cmd_t c);
      req0_x = 8'(c.x); req0_y = 7'(c.y); req0_w = DIM_W'(c.w);
      req0_h = DIM_W'(c.h); req0_colour = COLOUR_W'(c.col);
   endtask

   task automatic load1(input cmd_t c);
      req1_x = 8'(c.x); req1_y = 7'(c.y); req1_w = DIM_W'(c.w);
      req1_h = DIM_W'(c.h); req1_colour = COLOUR_W'(c.col);
   endtask

   // Hold each requester valid until it has issued its count of commands.
   // Called and returns just after a rising edge.
   task automatic drive(input int n0, input int n1, input cmd_t c0, input cmd_t c1);
      int  cnt0 = n0;
      int  cnt1 = n1;
      int  guard = 0;
      bit  hs0, hs1;
      load0(c0);
      load1(c1);
      req0_valid = (cnt0 > 0);
      req1_valid = (cnt1 > 0);
      while ((cnt0 > 0 || cnt1 > 0) && guard < 2000) begin
         @(negedge clk);
         guard++;
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         if (hs0) begin record(0, c0, cyc); cnt0--; end
         if (hs1) begin record(1, c1, cyc); cnt1--; end
         @(posedge clk);
         #1;
         req0_valid = (cnt0 > 0);
         req1_valid = (cnt1 > 0);
         // Scramble fields once a requester is finished: the engine must
         // be working from its latched copy.
         if (hs0 && cnt0 == 0) begin
            req0_x = 8'($urandom); req0_y = 7'($urandom); req0_colour = COLOUR_W'($urandom);
         end
         if (hs1 && cnt1 == 0) begin
            req1_x = 8'($urandom); req1_y = 7'($urandom); req1_colour = COLOUR_W'($urandom);
         end
      end
      if (guard >= 2000) check("handshake_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_pix.size() != 0 || exp_done.size() != 0) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         check("drain_timeout", 1, 0);
         exp_pix.delete();
         exp_done.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_plot"}, int'(plot), 0);
      check({tag, "_x"}, int'(x), 0);
      check({tag, "_y"}, int'(y), 0);
      check({tag, "_colour"}, int'(colour), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'({req0_done, req1_done}), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      cmd_t none = '{x: 0, y: 0, w: 0, h: 0, col: 0};
      int   t0;

      // Reset state
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      check("reset_ready", int'({req0_ready, req1_ready}), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Conflict fairness: two 1x1 commands each, both held valid.
      exp_grant = '{0, 1, 0, 1};
      hs_cyc.delete();
      busy_cnt = 0;
      drive(2, 2, '{x: 1, y: 1, w: 1, h: 1, col: 1}, '{x: 2, y: 2, w: 1, h: 1, col: 2});
      wait_idle();
      check("fair_hs_gap", hs_cyc[1] - hs_cyc[0], 2);
      check("fair_busy", busy_cnt, 4);

      // Single fill: 3x2 at (10,20), colour 4; done at T+7.
      hs_cyc.delete();
      busy_cnt = 0;
      drive(1, 0, '{x: 10, y: 20, w: 3, h: 2, col: 4}, none);
      wait_idle();
      check("fill_busy", busy_cnt, 6);

      // Clipping: 4x4 at (158,118) leaves only a 2x2 visible corner.
      busy_cnt = 0;
      drive(0, 1, none, '{x: 158, y: 118, w: 4, h: 4, col: 6});
      wait_idle();
      check("clip_busy", busy_cnt, 16);

      // Zero size from req0 with req1 waiting: last grant was req1, so
      // req0 goes first; req1 is accepted on req0's done cycle.
      exp_grant = '{0, 1};
      hs_cyc.delete();
      busy_cnt = 0;
      drive(1, 1, '{x: 40, y: 40, w: 0, h: 5, col: 7}, '{x: 50, y: 60, w: 1, h: 1, col: 3});
      wait_idle();
      check("zero_next_hs", hs_cyc[1] - hs_cyc[0], 2);
      check("zero_busy", busy_cnt, 2);

      // Back-to-back 2x1 commands from req1: plot 1,1,0,1,1,0,...
      hs_cyc.delete();
      busy_cnt = 0;
      drive(0, 3, none, '{x: 5, y: 7, w: 2, h: 1, col: 2});
      wait_idle();
      check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3);
      check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3);
      check("b2b_busy", busy_cnt, 6);

      // Reset mid-draw of an 8x8 fill: abort with no done pulse.
      hs_cyc.delete();
      drive(1, 0, '{x: 20, y: 30, w: 8, h: 8, col: 5}, none);
      t0 = hs_cyc[0];
      while (cyc < t0 + 10) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      exp_pix.delete();
      exp_done.delete();
      @(negedge clk);
      check_outputs_zero("midreset");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      // Grant history is reset: the first conflict goes to req0.
      exp_grant = '{0, 1};
      drive(1, 1, '{x: 100, y: 100, w: 2, h: 2, col: 1}, '{x: 110, y: 90, w: 1, h: 3, col: 6});
      wait_idle();

      check("pix_queue_empty", exp_pix.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Rectangle-fill engine that owns the single plot port of the 160x120 VGA adapter and shares it between two requesters: requester 0 (background/erase) and requester 1 (sprite draw driven by navigation state). It accepts one rectangle command at a time, scans it in raster order at one pixel per clock, and drives `x`/`y`/`colour`/`plot` straight into the adapter. Conflicting requests are resolved round-robin so neither requester can starve the other.

## Interface
- `DIM_W`, 6, width of rectangle width/height fields; maximum dimension 2^DIM_W-1 = 63
- `COLOUR_W`, 3, colour bits per pixel (1 bit per RGB channel)
- `clk`  in  1  system clock (CLOCK_50 domain)
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1 each  rectangle command pending
- `req0_ready`, `req1_ready`  out  1 each  command accepted this cycle (valid & ready = handshake)
- `reqN_x`  in  8  top-left x, 0..159
- `reqN_y`  in  7  top-left y, 0..119
- `reqN_w`, `reqN_h`  in  DIM_W  rectangle width/height in pixels
- `reqN_colour`  in  COLOUR_W  fill colour
- `req0_done`, `req1_done`  out  1 each  one-cycle pulse: that requester's rectangle is finished
- `x`  out  8  pixel x to adapter
- `y`  out  7  pixel y to adapter
- `colour`  out  COLOUR_W  pixel colour to adapter
- `plot`  out  1  adapter write enable
- `busy`  out  1  high while in DRAW

## Operation
- FSM states: IDLE, DRAW.
- IDLE: if exactly one `reqN_valid`, assert that `reqN_ready` (combinational from valid and state); if both valid, grant the requester not granted last (`last_grant` register; reset value = 1, so req0 wins first conflict). On handshake latch x0, y0, w, h, colour and granted id; clear counters cx=cy=0; update `last_grant`; go DRAW.
- `ready` is never asserted outside IDLE; at most one `ready` high per cycle.
- w=0 or h=0: command accepted, DRAW lasts one cycle with `plot`=0, then done pulse.
- DRAW: each cycle register outputs x=x0+cx, y=y0+cy, colour=latched colour, plot=1 unless clipped. Advance cx; when cx==w-1, cx<=0 and cy<=cy+1. After pixel (w-1,h-1) go IDLE.
- Arithmetic: x0+cx computed 9 bits, y0+cy computed 8 bits. Pixel clipped (plot=0, counters still advance, coordinate outputs still driven with low bits) if sum_x>=160 or sum_y>=120. No wrap-around onto the opposite edge.
- Done: the cycle the FSM returns to IDLE, `reqN_done` for the latched id pulses high for exactly one cycle.
- Inputs after handshake are ignored; requester may change them freely.
- Reset (any state, including mid-DRAW): state<=IDLE, plot<=0, x<=0, y<=0, colour<=0, done pulses<=0, counters<=0, last_grant<=1. Aborted rectangle produces no done pulse.

## Timing
- Handshake at cycle T; first pixel on outputs (plot=1) at T+1; last pixel at T+w*h; done pulse and IDLE at T+w*h+1.
- A new handshake can occur in the same cycle as a done pulse (back-to-back, no bubble beyond that one cycle): next first pixel at T+w*h+2.
- Zero-size command: handshake T, done at T+2, plot never high.
- `busy` high exactly during DRAW cycles, T+1..T+w*h (T+1 only for zero-size).
- All adapter-facing outputs registered; reset values all 0.

## Test plan
- Single fill: req0 x=10,y=20,w=3,h=2,colour=3'b100 -> plot high 6 consecutive cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) colour 4; req0_done one pulse at T+7.
- Conflict fairness: both valid continuously with 1x1 commands -> grants alternate 0,1,0,1; first grant req0; each done pulse matches granted id.
- Clipping: req1 x=158,y=118,w=4,h=4 -> 16 DRAW cycles, plot=1 only at (158,118),(159,118),(158,119),(159,119); req1_done at T+17.
- Zero size: req0 w=0,h=5 -> no plot, busy one cycle, req0_done at T+2; req1 pending meanwhile is accepted on done cycle.
- Reset mid-draw: 8x8 fill, assert reset at pixel 10 -> next cycle plot=0, x=y=colour=0, busy=0, no done; following conflict grants req0.
- Back-to-back: req1 held valid with 2x1 commands -> plot pattern 1,1,0,1,1,0…; ready never high while busy.
